// File: rtl/shifter_operand_fetch.sv
// Operand-2 front end: decodes I/shift fields, fetches Rs/Rm over one read port, normalises ARM shift quirks.
// Latency accept->out_valid: imm 1, imm-shift 2, reg-shift 3 cycles (zero-wait acks); bundle held until in_ready.
module shifter_operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        out_ready,
  input  logic [31:0] in_instr,
  input  logic        in_carry,
  output logic        out_rf_req,
  output logic [3:0]  out_rf_addr,
  input  logic        in_rf_ack,
  input  logic [31:0] in_rf_data,
  output logic        out_valid,
  input  logic        in_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_shift_value,
  output logic [2:0]  out_op_select,
  output logic        out_carry,
  output logic        out_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ_RS = 3'd1,
    READ_RM = 3'd2,
    OUT     = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_RRX = 3'b100;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_rs_addr;
  logic [3:0]  r_rm_addr;
  logic        r_carry;
  logic [31:0] r_data;
  logic [31:0] r_shift;
  logic [2:0]  r_op;

  logic        w_accept;
  logic [4:0]  w_amt;
  logic [1:0]  w_type;
  logic [2:0]  w_op_dec;
  logic [31:0] w_shift_dec;
  logic        w_unused;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_amt    = in_instr[11:7];
  assign w_type   = in_instr[6:5];
  assign w_unused = &{1'b0, in_instr[31:26], in_instr[24:12]};

  // Shift normalisation: LSR/ASR #0 mean 32, ROR #0 means RRX by one.
  always_comb begin
    w_op_dec    = OP_LSL;
    w_shift_dec = '0;
    if (in_instr[25]) begin
      w_op_dec    = OP_ROR;
      w_shift_dec = {27'b0, in_instr[11:8], 1'b0};
    end else if (!in_instr[4]) begin
      case (w_type)
        2'b00: begin
          w_op_dec    = OP_LSL;
          w_shift_dec = {27'b0, w_amt};
        end
        2'b01, 2'b10: begin
          w_op_dec    = {1'b0, w_type};
          w_shift_dec = (w_amt == 5'd0) ? 32'd32 : {27'b0, w_amt};
        end
        default: begin
          w_op_dec    = (w_amt == 5'd0) ? OP_RRX : OP_ROR;
          w_shift_dec = (w_amt == 5'd0) ? 32'd1 : {27'b0, w_amt};
        end
      endcase
    end else begin
      w_op_dec    = {1'b0, w_type};
      w_shift_dec = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (in_instr[25])     w_next = OUT;
          else if (!in_instr[4]) w_next = READ_RM;
          else if (in_instr[7])  w_next = ERR;
          else                   w_next = READ_RS;
        end
      end
      READ_RS: if (in_rf_ack) w_next = READ_RM;
      READ_RM: if (in_rf_ack) w_next = OUT;
      OUT:     if (in_ready)  w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    out_ready   = (r_state == IDLE);
    out_rf_req  = (r_state == READ_RS) || (r_state == READ_RM);
    out_valid   = (r_state == OUT);
    out_err     = (r_state == ERR);
    out_rf_addr = '0;
    if (r_state == READ_RS)      out_rf_addr = r_rs_addr;
    else if (r_state == READ_RM) out_rf_addr = r_rm_addr;
  end

  // r_data is preloaded with imm8; register paths overwrite it on the Rm ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs_addr <= '0;
      r_rm_addr <= '0;
      r_carry   <= 1'b0;
      r_data    <= '0;
      r_shift   <= '0;
      r_op      <= '0;
    end else begin
      if (w_accept) begin
        r_rs_addr <= in_instr[11:8];
        r_rm_addr <= in_instr[3:0];
        r_carry   <= in_carry;
        r_data    <= {24'b0, in_instr[7:0]};
        r_shift   <= w_shift_dec;
        r_op      <= w_op_dec;
      end
      if ((r_state == READ_RS) && in_rf_ack) r_shift <= {24'b0, in_rf_data[7:0]};
      if ((r_state == READ_RM) && in_rf_ack) r_data  <= in_rf_data;
    end
  end

  assign out_data        = r_data;
  assign out_shift_value = r_shift;
  assign out_op_select   = r_op;
  assign out_carry       = r_carry;

endmodule

// File: tb/tb_shifter_operand_fetch.sv
// Directed bench for shifter_operand_fetch: inputs driven and outputs checked on the falling edge.
module tb_shifter_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic        in_carry;
  logic        out_rf_req;
  logic [3:0]  out_rf_addr;
  logic        in_rf_ack;
  logic [31:0] in_rf_data;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [31:0] out_shift_value;
  logic [2:0]  out_op_select;
  logic        out_carry;
  logic        out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shifter_operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .out_ready(out_ready),
    .in_instr(in_instr), .in_carry(in_carry), .out_rf_req(out_rf_req),
    .out_rf_addr(out_rf_addr), .in_rf_ack(in_rf_ack), .in_rf_data(in_rf_data),
    .out_valid(out_valid), .in_ready(in_ready), .out_data(out_data),
    .out_shift_value(out_shift_value), .out_op_select(out_op_select),
    .out_carry(out_carry), .out_err(out_err)
  );

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_carry = 1'b0;
    in_rf_ack = 1'b0; in_rf_data = '0; in_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({out_ready, out_rf_req, out_rf_addr, out_valid, out_data, out_shift_value,
         out_op_select, out_carry, out_err} !== {1'b1, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 3'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b req=%b addr=%h vld=%b data=%h sh=%h op=%b c=%b err=%b, want rdy=1 rest 0",
               out_ready, out_rf_req, out_rf_addr, out_valid, out_data, out_shift_value, out_op_select, out_carry, out_err);
    end
  endtask

  task automatic test_immediate;
    // imm8=0xFF, rot=4 -> ROR by 8, carry passes through
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h0200_04FF; in_carry = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_instr = 32'hFFFF_FFFF; in_carry = 1'b0;
    n_cmp++;
    if ({out_valid, out_rf_req, out_ready, out_data, out_shift_value, out_op_select, out_carry}
        !== {1'b1, 1'b0, 1'b0, 32'h0000_00FF, 32'd8, 3'b011, 1'b1}) begin
      n_bad++;
      $display("FAIL imm_rot4: vld=%b req=%b rdy=%b data=%h sh=%0d op=%b c=%b, want 1 0 0 000000ff 8 011 1",
               out_valid, out_rf_req, out_ready, out_data, out_shift_value, out_op_select, out_carry);
    end
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    n_cmp++;
    if ({out_valid, out_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL imm_return_idle: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, out_ready);
    end
    // rot=0: pass-through, carry 0
    in_valid = 1'b1; in_instr = 32'h0200_00AB; in_carry = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, out_shift_value, out_op_select, out_carry}
        !== {1'b1, 32'h0000_00AB, 32'd0, 3'b011, 1'b0}) begin
      n_bad++;
      $display("FAIL imm_rot0: vld=%b data=%h sh=%0d op=%b c=%b, want 1 000000ab 0 011 0",
               out_valid, out_data, out_shift_value, out_op_select, out_carry);
    end
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
  endtask

  task automatic test_imm_shift;
    // LSR #0, Rm=3 -> shift of 32
    in_valid = 1'b1; in_instr = 32'h0000_0023; in_carry = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_rf_req, out_rf_addr, out_valid} !== {1'b1, 4'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL lsr0_read: req=%b addr=%0d vld=%b, want 1 3 0", out_rf_req, out_rf_addr, out_valid);
    end
    in_rf_ack = 1'b1; in_rf_data = 32'h8000_0001;
    @(negedge clk);
    in_rf_ack = 1'b0; in_rf_data = 32'h0;
    n_cmp++;
    if ({out_valid, out_rf_req, out_data, out_shift_value, out_op_select, out_carry}
        !== {1'b1, 1'b0, 32'h8000_0001, 32'd32, 3'b001, 1'b0}) begin
      n_bad++;
      $display("FAIL lsr0_bundle: vld=%b req=%b data=%h sh=%0d op=%b c=%b, want 1 0 80000001 32 001 0",
               out_valid, out_rf_req, out_data, out_shift_value, out_op_select, out_carry);
    end
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    // ROR #0 -> RRX by 1
    in_valid = 1'b1; in_instr = 32'h0000_0063; in_carry = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_carry = 1'b0;
    in_rf_ack = 1'b1; in_rf_data = 32'h8000_0001;
    @(negedge clk);
    in_rf_ack = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, out_shift_value, out_op_select, out_carry}
        !== {1'b1, 32'h8000_0001, 32'd1, 3'b100, 1'b1}) begin
      n_bad++;
      $display("FAIL ror0_rrx: vld=%b data=%h sh=%0d op=%b c=%b, want 1 80000001 1 100 1",
               out_valid, out_data, out_shift_value, out_op_select, out_carry);
    end
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
  endtask

  task automatic test_reg_shift;
    // Rs=5, LSL by register, Rm=2; Rs ack after two wait cycles
    in_valid = 1'b1; in_instr = 32'h0000_0512; in_carry = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({out_rf_req, out_rf_addr} !== {1'b1, 4'd5}) begin
        n_bad++;
        $display("FAIL rs_read_wait%0d: req=%b addr=%0d, want 1 5", i, out_rf_req, out_rf_addr);
      end
      if (i == 2) begin
        in_rf_ack = 1'b1; in_rf_data = 32'hFFFF_FF21;
      end
      @(negedge clk);
    end
    in_rf_data = 32'h1234_5678;
    n_cmp++;
    if ({out_rf_req, out_rf_addr, out_valid} !== {1'b1, 4'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL rm_read: req=%b addr=%0d vld=%b, want 1 2 0", out_rf_req, out_rf_addr, out_valid);
    end
    @(negedge clk);
    in_rf_ack = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, out_shift_value, out_op_select}
        !== {1'b1, 32'h1234_5678, 32'h21, 3'b000}) begin
      n_bad++;
      $display("FAIL reg_shift_bundle: vld=%b data=%h sh=%h op=%b, want 1 12345678 21 000",
               out_valid, out_data, out_shift_value, out_op_select);
    end
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    // ASR #5, Rm=7; input noise while waiting must not disturb the bundle
    in_valid = 1'b1; in_instr = 32'h0000_02C7; in_carry = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_rf_ack = 1'b1; in_rf_data = 32'hDEAD_BEEF;
    @(negedge clk);
    in_rf_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'h0200_0000 ^ (32'h0000_0FFF * i); in_carry = i[0];
      in_rf_data = 32'h5555_0000 + i; in_rf_ack = i[0];
      n_cmp++;
      if ({out_valid, out_ready, out_data, out_shift_value, out_op_select, out_carry}
          !== {1'b1, 1'b0, 32'hDEAD_BEEF, 32'd5, 3'b010, 1'b1}) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: vld=%b rdy=%b data=%h sh=%0d op=%b c=%b, want 1 0 deadbeef 5 010 1",
                 i, out_valid, out_ready, out_data, out_shift_value, out_op_select, out_carry);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_rf_ack = 1'b0; in_ready = 1'b1;
    n_cmp++;
    if ({out_valid, out_data} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL hold_release: vld=%b data=%h, want 1 deadbeef", out_valid, out_data);
    end
    @(negedge clk);
    in_ready = 1'b0;
    n_cmp++;
    if ({out_valid, out_ready, out_rf_req} !== 3'b010) begin
      n_bad++;
      $display("FAIL hold_idle: vld=%b rdy=%b req=%b, want 0 1 0", out_valid, out_ready, out_rf_req);
    end
  endtask

  task automatic test_illegal;
    in_valid = 1'b1; in_instr = 32'h0000_0090; in_carry = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_err, out_rf_req, out_valid, out_ready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL illegal_pulse: err=%b req=%b vld=%b rdy=%b, want 1 0 0 0", out_err, out_rf_req, out_valid, out_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_err, out_rf_req, out_valid, out_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL illegal_after: err=%b req=%b vld=%b rdy=%b, want 0 0 0 1", out_err, out_rf_req, out_valid, out_ready);
    end
  endtask

  task automatic test_reset_mid_read;
    in_valid = 1'b1; in_instr = 32'h0000_0512; in_carry = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({out_rf_req, out_rf_addr} !== {1'b1, 4'd5}) begin
      n_bad++;
      $display("FAIL midrd_in_rs: req=%b addr=%0d, want 1 5", out_rf_req, out_rf_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({out_rf_req, out_valid, out_ready, out_carry, out_data, out_shift_value}
        !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL midrd_reset: req=%b vld=%b rdy=%b c=%b data=%h sh=%h, want 0 0 1 0 0 0",
               out_rf_req, out_valid, out_ready, out_carry, out_data, out_shift_value);
    end
    in_rf_ack = 1'b1; in_rf_data = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    in_rf_ack = 1'b0;
    n_cmp++;
    if ({out_rf_req, out_valid, out_ready, out_data, out_shift_value}
        !== {1'b0, 1'b0, 1'b1, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL midrd_stray_ack: req=%b vld=%b rdy=%b data=%h sh=%h, want 0 0 1 0 0",
               out_rf_req, out_valid, out_ready, out_data, out_shift_value);
    end
  endtask

  initial begin
    test_reset;
    test_immediate;
    test_imm_shift;
    test_reg_shift;
    test_backpressure;
    test_illegal;
    test_reset_mid_read;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
